booth_seq_ctrl: RTL and testbench

BOOTH_SEQ_CTRL -- requirements
Module: booth_seq_ctrl

---
 rtl/booth_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_booth_seq_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-4 Booth multiplier controller: one Booth digit per RUN cycle.
// Define BOOTH_SIGNED_EN for 8-bit two's-complement operands (4 digits); default is unsigned (5 digits).
module booth_seq_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  multiplicand,
   input  logic [7:0]  multiplier,
   output logic        busy,
   output logic [2:0]  action,
   output logic [2:0]  step,
   output logic [15:0] product,
   output logic        done
);

`ifdef BOOTH_SIGNED_EN
   localparam logic [2:0] LAST_STEP = 3'd3;
`else
   localparam logic [2:0] LAST_STEP = 3'd4;
`endif

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t      state, state_nxt;
   logic [7:0]  m_reg, q_reg;
   logic [15:0] acc;
   logic [2:0]  step_cnt;
   logic [15:0] m_ext;
   logic [10:0] q_ext;
   logic [2:0]  digit;
   logic [2:0]  act_code;
   logic [15:0] pp, pp_sh, acc_sum;

   // Q carries an implicit Q[-1]=0 at bit 0, so digit i sits at q_ext[2i+2:2i].
   always_comb begin
`ifdef BOOTH_SIGNED_EN
      m_ext = {{8{m_reg[7]}}, m_reg};
      q_ext = {{2{q_reg[7]}}, q_reg, 1'b0};
`else
      m_ext = {8'h00, m_reg};
      q_ext = {2'b00, q_reg, 1'b0};
`endif
   end

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      digit = q_ext[10:8];
      case (step_cnt)
         3'd0:    digit = q_ext[2:0];
         3'd1:    digit = q_ext[4:2];
         3'd2:    digit = q_ext[6:4];
         3'd3:    digit = q_ext[8:6];
         default: digit = q_ext[10:8];
      endcase
   end

   always_comb begin
      act_code = 3'd0;
      pp       = 16'h0000;
      case (digit)
         3'b001, 3'b010: begin act_code = 3'd1; pp = m_ext;              end
         3'b011:         begin act_code = 3'd2; pp = m_ext << 1;         end
         3'b100:         begin act_code = 3'd4; pp = -(m_ext << 1);      end
         3'b101, 3'b110: begin act_code = 3'd3; pp = -m_ext;             end
         3'b111:         begin act_code = 3'd7; pp = 16'h0000;           end
         default:        begin act_code = 3'd0; pp = 16'h0000;           end
      endcase
      pp_sh   = pp << {step_cnt, 1'b0};
      acc_sum = acc + pp_sh;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (step_cnt == LAST_STEP) state_nxt = FIN;
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_reg    <= 8'h00;
         q_reg    <= 8'h00;
         acc      <= 16'h0000;
         step_cnt <= 3'd0;
         product  <= 16'h0000;
      end else begin
         case (state)
            IDLE: if (start) begin
               m_reg    <= multiplicand;
               q_reg    <= multiplier;
               acc      <= 16'h0000;
               step_cnt <= 3'd0;
            end
            RUN: begin
               acc      <= acc_sum;
               step_cnt <= step_cnt + 3'd1;
               // The final digit's sum lands in product at the same edge that enters FIN.
               if (step_cnt == LAST_STEP) product <= acc_sum;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy   = (state == RUN);
      done   = (state == FIN);
      action = (state == RUN) ? act_code : 3'd0;
      step   = (state == RUN) ? step_cnt : 3'd0;
   end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Self-checking bench for booth_seq_ctrl: directed vector table plus busy/reset/FIN corner sequences.
module tb_booth_seq_ctrl;

`ifdef BOOTH_SIGNED_EN
   localparam int N = 4;
`else
   localparam int N = 5;
`endif

   typedef struct packed {
      logic [7:0]       m;
      logic [7:0]       q;
      logic [15:0]      p;
      logic [4:0][2:0]  act;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [7:0]  multiplicand, multiplier;
   logic        busy, done;
   logic [2:0]  action, step;
   logic [15:0] product;

   int checks = 0;
   int errors = 0;
   logic [15:0] last_p;
   vec_t vecs [6];

   booth_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .busy(busy), .action(action), .step(step),
      .product(product), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] m, input logic [7:0] q, input logic [15:0] p,
                               input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                               input logic [2:0] a3, input logic [2:0] a4);
      vec_t v;
      v.m = m; v.q = q; v.p = p;
      v.act = {a4, a3, a2, a1, a0};
      return v;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"},   busy,   0);
      check({tag, "_done"},   done,   0);
      check({tag, "_action"}, action, 0);
      check({tag, "_step"},   step,   0);
      check({tag, "_prod"},   product, last_p);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after FIN.
   task automatic run_op(input vec_t v, input string tag);
      multiplicand = v.m;
      multiplier   = v.q;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < N; i++) begin
         check({tag, "_run_busy"}, busy, 1);
         check({tag, "_run_done"}, done, 0);
         check({tag, "_run_step"}, step, i);
         check({tag, "_run_action"}, action, v.act[i]);
         check({tag, "_run_prod_hold"}, product, last_p);
         @(negedge clk);
      end
      check({tag, "_fin_done"}, done, 1);
      check({tag, "_fin_busy"}, busy, 0);
      check({tag, "_fin_action"}, action, 0);
      check({tag, "_fin_step"}, step, 0);
      check({tag, "_fin_prod"}, product, v.p);
      last_p = v.p;
      @(negedge clk);
      check_idle({tag, "_post"});
   endtask

   initial begin
`ifdef BOOTH_SIGNED_EN
      vecs[0] = mk(8'h07, 8'h03, 16'h0015, 3, 1, 0, 0, 0);
      vecs[1] = mk(8'h80, 8'h5A, 16'hD300, 4, 3, 2, 1, 0);
      vecs[2] = mk(8'h80, 8'h80, 16'h4000, 0, 0, 0, 4, 0);
      vecs[3] = mk(8'h80, 8'h7F, 16'hC080, 3, 7, 7, 2, 0);
      vecs[4] = mk(8'hFF, 8'hFF, 16'h0001, 3, 7, 7, 7, 0);
      vecs[5] = mk(8'h00, 8'h55, 16'h0000, 1, 1, 1, 1, 0);
`else
      vecs[0] = mk(8'h07, 8'h03, 16'h0015, 3, 1, 0, 0, 0);
      vecs[1] = mk(8'h80, 8'h5A, 16'h2D00, 4, 3, 2, 1, 0);
      vecs[2] = mk(8'h80, 8'h80, 16'h4000, 0, 0, 0, 4, 1);
      vecs[3] = mk(8'h80, 8'h7F, 16'h3F80, 3, 7, 7, 2, 0);
      vecs[4] = mk(8'hFF, 8'hFF, 16'hFE01, 3, 7, 7, 7, 1);
      vecs[5] = mk(8'h00, 8'h55, 16'h0000, 1, 1, 1, 1, 0);
`endif
      last_p       = 16'h0000;
      rst          = 1'b1;
      start        = 1'b1;
      multiplicand = 8'h12;
      multiplier   = 8'h34;
      // Reset wins over a simultaneous start.
      repeat (2) @(negedge clk);
      check_idle("reset");
      rst   = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_idle("idle");

      // Back-to-back: each op starts in the IDLE cycle right after the previous FIN.
      for (int k = 0; k < 6; k++) run_op(vecs[k], $sformatf("vec%0d", k));

      // Start with new operands held through RUN and FIN must not disturb the op in flight.
      multiplicand = 8'h07;
      multiplier   = 8'h03;
      start        = 1'b1;
      @(negedge clk);
      multiplicand = 8'h80;
      multiplier   = 8'h80;
      for (int i = 0; i < N; i++) begin
         check("busy_ign_busy", busy, 1);
         check("busy_ign_step", step, i);
         @(negedge clk);
      end
      check("busy_ign_done", done, 1);
      check("busy_ign_prod", product, 16'h0015);
      last_p = 16'h0015;
      @(negedge clk);
      start = 1'b0;
      check("fin_start_ign_busy", busy, 0);
      check("fin_start_ign_done", done, 0);
      check("fin_start_ign_prod", product, 16'h0015);
      @(negedge clk);
      check_idle("after_ign");

      // Reset in the 2nd RUN cycle: back to IDLE, product cleared, no done pulse.
      multiplicand = 8'hFF;
      multiplier   = 8'hFF;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("rst_mid_run0_busy", busy, 1);
      @(negedge clk);
      check("rst_mid_run1_step", step, 1);
      rst = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      last_p = 16'h0000;
      check_idle("rst_mid");
      for (int i = 0; i < N + 2; i++) begin
         @(negedge clk);
         check("rst_mid_no_done", done, 0);
         check("rst_mid_no_busy", busy, 0);
      end

      // Operation after a mid-run reset completes normally.
      run_op(vecs[0], "after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
